// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb countdown timer: BCD digit type,
// countdown state encoding and the level-0 default time.
package bomb_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam bcd_digit_t DEF_THREE = 4'd2;
  localparam bcd_digit_t DEF_TWO   = 4'd0;
  localparam bcd_digit_t DEF_ONE   = 4'd0;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a borrow-chained decrementer; a zero digit that must
// lend rolls to 9 and passes the borrow on.
module bcd_digit_dec
  import bomb_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t next_digit,
  output logic       borrow_out
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = 4'd9;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bomb_countdown_timer.sv
// Three-digit BCD countdown with load/start/stop control and expiry flags.
// Optional `warning` output is built only when COUNTDOWN_WARN_EN is defined.
module bomb_countdown_timer
  import bomb_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int WARN_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] value_three,
  input  logic [3:0] value_two,
  input  logic [3:0] value_one,
  output logic [3:0] digit_three,
  output logic [3:0] digit_two,
  output logic [3:0] digit_one,
  output logic       running,
  output logic       expired,
  output logic       expired_pulse,
  output logic       warning
);

  localparam int             CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  bcd_digit_t       dec_three, dec_two, dec_one;
  bcd_digit_t       next_three, next_two, next_one;
  logic             borrow_one, borrow_two, borrow_three;
  logic             time_nz, dec_zero, do_dec;

  function automatic bcd_digit_t sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  bcd_digit_dec u_dec_one (
    .digit(digit_one), .borrow_in(1'b1),
    .next_digit(dec_one), .borrow_out(borrow_one)
  );
  bcd_digit_dec u_dec_two (
    .digit(digit_two), .borrow_in(borrow_one),
    .next_digit(dec_two), .borrow_out(borrow_two)
  );
  bcd_digit_dec u_dec_three (
    .digit(digit_three), .borrow_in(borrow_two),
    .next_digit(dec_three), .borrow_out(borrow_three)
  );

  assign time_nz  = (digit_three != 4'd0) || (digit_two != 4'd0) || (digit_one != 4'd0);
  assign dec_zero = (dec_three == 4'd0) && (dec_two == 4'd0) && (dec_one == 4'd0);
  assign tick     = (state == RUN) && (cnt == CNT_MAX);
  // A borrow out of the hundreds digit means 000 would wrap, so it blocks the decrement.
  assign do_dec   = tick && !stop && !borrow_three;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (load) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: if (start) next_state = time_nz ? RUN : EXPIRED;
        RUN: begin
          if (stop)                  next_state = PAUSE;
          else if (tick && dec_zero) next_state = EXPIRED;
        end
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    running = (state == RUN);
    expired = (state == EXPIRED);
  end

  // Stop freezes the prescaler so a resume finishes the partial second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (state == RUN) begin
      if (!stop) cnt <= tick ? '0 : cnt + 1'b1;
    end else if (start && state == IDLE) begin
      cnt <= '0;
    end
  end

  always_comb begin
    next_three = digit_three;
    next_two   = digit_two;
    next_one   = digit_one;
    if (load) begin
      next_three = sat9(value_three);
      next_two   = sat9(value_two);
      next_one   = sat9(value_one);
    end else if (do_dec) begin
      next_three = dec_three;
      next_two   = dec_two;
      next_one   = dec_one;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_three   <= DEF_THREE;
      digit_two     <= DEF_TWO;
      digit_one     <= DEF_ONE;
      expired_pulse <= 1'b0;
    end else begin
      digit_three   <= next_three;
      digit_two     <= next_two;
      digit_one     <= next_one;
      expired_pulse <= (next_state == EXPIRED) && (state != EXPIRED);
    end
  end

`ifdef COUNTDOWN_WARN_EN
  localparam logic [9:0] WARN_LIM = 10'(WARN_SECS);
  logic [9:0] next_secs;

  assign next_secs = 10'(next_three) * 10'd100 + 10'(next_two) * 10'd10 + 10'(next_one);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) warning <= 1'b0;
    else       warning <= (next_state == RUN) && (next_secs != 10'd0) && (next_secs <= WARN_LIM);
  end
`else
  assign warning = 1'b0;
`endif

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// Table-driven scoreboard bench for bomb_countdown_timer with TICK_DIV=4.
module tb_bomb_countdown_timer;

  localparam int TICK_DIV  = 4;
  localparam int WARN_SECS = 10;
`ifdef COUNTDOWN_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, load, start, stop;
  logic [3:0] value_three, value_two, value_one;
  logic [3:0] digit_three, digit_two, digit_one;
  logic       running, expired, expired_pulse, warning;

  bomb_countdown_timer #(.TICK_DIV(TICK_DIV), .WARN_SECS(WARN_SECS)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
    .value_three(value_three), .value_two(value_two), .value_one(value_one),
    .digit_three(digit_three), .digit_two(digit_two), .digit_one(digit_one),
    .running(running), .expired(expired), .expired_pulse(expired_pulse),
    .warning(warning)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       ld, st, sp;
    logic [3:0] v3, v2, v1;
    logic [3:0] e3, e2, e1;
    logic       er, ee, ep;
  } vec_t;

  typedef logic [15:0] obs_t;

  vec_t  vecs[$];
  obs_t  sb[$];
  string sb_tag[$];
  int    checks = 0;
  int    failures = 0;

  function automatic vec_t mk(string tag, logic ld, logic st, logic sp,
                              logic [3:0] v3, logic [3:0] v2, logic [3:0] v1,
                              logic [3:0] e3, logic [3:0] e2, logic [3:0] e1,
                              logic er, logic ee, logic ep);
    vec_t v;
    v.tag = tag; v.ld = ld; v.st = st; v.sp = sp;
    v.v3 = v3; v.v2 = v2; v.v1 = v1;
    v.e3 = e3; v.e2 = e2; v.e1 = e1;
    v.er = er; v.ee = ee; v.ep = ep;
    return v;
  endfunction

  function automatic logic exp_warn(logic [3:0] e3, logic [3:0] e2, logic [3:0] e1, logic er);
    int secs;
    secs = int'(e3) * 100 + int'(e2) * 10 + int'(e1);
    return WARN_EN && er && (secs > 0) && (secs <= WARN_SECS);
  endfunction

  task automatic check_out(string tag, obs_t exp);
    obs_t act;
    act = {digit_three, digit_two, digit_one, running, expired, expired_pulse, warning};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got digits=%h flags(run,exp,pulse,warn)=%b required digits=%h flags=%b",
               tag, act[15:4], act[3:0], exp[15:4], exp[3:0]);
    end
  endtask

  task automatic apply(vec_t v);
    load = v.ld; start = v.st; stop = v.sp;
    value_three = v.v3; value_two = v.v2; value_one = v.v1;
    sb.push_back({v.e3, v.e2, v.e1, v.er, v.ee, v.ep, exp_warn(v.e3, v.e2, v.e1, v.er)});
    sb_tag.push_back(v.tag);
    @(posedge clk);
    #1;
    check_out(sb_tag.pop_front(), sb.pop_front());
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic nop(string tag, logic [3:0] e3, logic [3:0] e2, logic [3:0] e1,
                     logic er, logic ee);
    apply(mk(tag, 0, 0, 0, 0, 0, 0, e3, e2, e1, er, ee, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Borrow chain 012 -> 011 -> 010 -> 009
    vecs.push_back(mk("a_load",  1, 0, 0, 0, 1, 2, 0, 1, 2, 0, 0, 0));
    vecs.push_back(mk("a_start", 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("a_run012", 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    vecs.push_back(mk("a_dec011", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("a_run011", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("a_dec010", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("a_run010", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk("a_borrow009", 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0));
    // Run to expiry from 002, then hold 000
    vecs.push_back(mk("b_load",  1, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk("b_start", 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("b_run002", 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("b_dec001", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("b_run001", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("b_expire", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk("b_hold000", 0, (i == 5), (i == 9), 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Stop/resume keeps the partial prescaler count
    vecs.push_back(mk("c_load100", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c_start",   0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("c_run100", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("c_dec099", 0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 0, 0));
    vecs.push_back(mk("c_run099", 0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 0, 0));
    vecs.push_back(mk("c_stop",   0, 0, 1, 0, 0, 0, 0, 9, 9, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk("c_paused", 0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0));
    vecs.push_back(mk("c_resume", 0, 1, 0, 0, 0, 0, 0, 9, 9, 1, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk("c_partial", 0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 0, 0));
    vecs.push_back(mk("c_dec098", 0, 0, 0, 0, 0, 0, 0, 9, 8, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("c_run098", 0, 0, 0, 0, 0, 0, 0, 9, 8, 1, 0, 0));
    vecs.push_back(mk("c_stop_tick", 0, 0, 1, 0, 0, 0, 0, 9, 8, 0, 0, 0));
    vecs.push_back(mk("c_start2",    0, 1, 0, 0, 0, 0, 0, 9, 8, 1, 0, 0));
    vecs.push_back(mk("c_load_tick", 1, 0, 0, 0, 4, 5, 0, 4, 5, 0, 0, 0));
    vecs.push_back(mk("c_sat_two",   1, 0, 0, 0, 4'hC, 0, 0, 9, 0, 0, 0, 0));
    vecs.push_back(mk("c_sat_all",   1, 0, 0, 4'hF, 3, 4'hA, 9, 3, 9, 0, 0, 0));
    vecs.push_back(mk("c_load000",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c_start000",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("c_exp_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("c_exp_stop",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("c_exp_start", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    value_three = 4'd0; value_two = 4'd0; value_one = 4'd0;
    #23;
    check_out("reset_values", {4'd2, 4'd0, 4'd0, 4'b0000});
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3 * TICK_DIV; i++) nop("idle_stable", 2, 0, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset in the middle of a run
    apply(mk("r_load005", 1, 0, 0, 0, 0, 5, 0, 0, 5, 0, 0, 0));
    apply(mk("r_start",   0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
    nop("r_run005", 0, 0, 5, 1, 0);
    reset = 1'b1;
    #2;
    check_out("async_reset", {4'd2, 4'd0, 4'd0, 4'b0000});
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset_idle", {4'd2, 4'd0, 4'd0, 4'b0000});
    apply(mk("r_restart", 0, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) nop("r_run200", 2, 0, 0, 1, 0);
    nop("r_dec199", 1, 9, 9, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
